// File: rtl/exe_stage_mc_if.sv
// Handshake and datapath bundle between the ID/EXE register, the execute
// stage and the memory stage.
interface exe_stage_mc_if #(
    parameter int DATA_W = 32,
    parameter int DEST_W = 5
);
    logic              in_valid;
    logic [3:0]        EXE_CMD;
    logic [1:0]        val1_sel;
    logic [1:0]        val2_sel;
    logic [1:0]        ST_val_sel;
    logic [DATA_W-1:0] val1;
    logic [DATA_W-1:0] val2;
    logic [DATA_W-1:0] ST_value_in;
    logic [DATA_W-1:0] ALU_res_MEM;
    logic [DATA_W-1:0] result_WB;
    logic [DEST_W-1:0] dest_in;
    logic              mem_stall;
    logic              exe_busy;
    logic              out_valid;
    logic [DATA_W-1:0] ALUResult;
    logic [DATA_W-1:0] ST_value_out;
    logic [DEST_W-1:0] dest_out;

    modport master (
        output in_valid, EXE_CMD, val1_sel, val2_sel, ST_val_sel,
               val1, val2, ST_value_in, ALU_res_MEM, result_WB,
               dest_in, mem_stall,
        input  exe_busy, out_valid, ALUResult, ST_value_out, dest_out
    );

    modport slave (
        input  in_valid, EXE_CMD, val1_sel, val2_sel, ST_val_sel,
               val1, val2, ST_value_in, ALU_res_MEM, result_WB,
               dest_in, mem_stall,
        output exe_busy, out_valid, ALUResult, ST_value_out, dest_out
    );
endinterface

// File: rtl/exe_stage_mc.sv
// Execute stage: operand forwarding, single-cycle ALU, multi-cycle MUL and
// the EXE/MEM output register.
module exe_stage_mc #(
    parameter int DATA_W  = 32,
    parameter int DEST_W  = 5,
    parameter int MUL_LAT = 4
) (
    input  logic          clk,
    input  logic          rst,
    exe_stage_mc_if.slave bus
);

    localparam int         SH_W     = $clog2(DATA_W);
    localparam logic [3:0] CNT_LOAD = 4'(MUL_LAT - 1);

    typedef enum logic [1:0] {
        IDLE,
        MUL_RUN,
        MUL_HOLD
    } state_e;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_XOR  = 4'h5,
        OP_SLL  = 4'h6,
        OP_SRL  = 4'h7,
        OP_SRA  = 4'h8,
        OP_SLT  = 4'h9,
        OP_SLTU = 4'hA,
        OP_MUL  = 4'hB
    } op_e;

    state_e            state;
    logic [3:0]        cnt;
    logic              busy_q;
    logic              ov_q;
    logic [DATA_W-1:0] res_q;
    logic [DATA_W-1:0] st_q;
    logic [DEST_W-1:0] dest_q;

    logic [DATA_W-1:0] mul_a;
    logic [DATA_W-1:0] mul_b;
    logic [DATA_W-1:0] mul_s;
    logic [DEST_W-1:0] mul_dest;

    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] s;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] mul_lo;
    logic [SH_W-1:0]   sh;
    logic              accept;
    logic              is_mul;

    function automatic logic [DATA_W-1:0] fwd_sel(
        input logic [1:0]        sel,
        input logic [DATA_W-1:0] own,
        input logic [DATA_W-1:0] mem,
        input logic [DATA_W-1:0] wb
    );
        logic [DATA_W-1:0] r;
        unique case (sel)
            2'b01:   r = mem;
            2'b10:   r = wb;
            default: r = own;
        endcase
        return r;
    endfunction

    assign a = fwd_sel(bus.val1_sel, bus.val1, bus.ALU_res_MEM, bus.result_WB);
    assign b = fwd_sel(bus.val2_sel, bus.val2, bus.ALU_res_MEM, bus.result_WB);
    assign s = fwd_sel(bus.ST_val_sel, bus.ST_value_in, bus.ALU_res_MEM, bus.result_WB);

    assign sh     = b[SH_W-1:0];
    assign is_mul = (bus.EXE_CMD == OP_MUL);
    // busy_q is zero only in IDLE, so accepts can only happen there.
    assign accept = bus.in_valid & ~busy_q & ~bus.mem_stall;
    assign mul_lo = mul_a * mul_b;

    always_comb begin
        alu_res = b;
        case (bus.EXE_CMD)
            OP_NOP:  alu_res = '0;
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_SLL:  alu_res = a << sh;
            OP_SRL:  alu_res = a >> sh;
            OP_SRA:  alu_res = $signed(a) >>> sh;
            OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_res = {{(DATA_W-1){1'b0}}, (a < b)};
            default: alu_res = b;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            busy_q   <= 1'b0;
            ov_q     <= 1'b0;
            res_q    <= '0;
            st_q     <= '0;
            dest_q   <= '0;
            mul_a    <= '0;
            mul_b    <= '0;
            mul_s    <= '0;
            mul_dest <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept && is_mul) begin
                        mul_a    <= a;
                        mul_b    <= b;
                        mul_s    <= s;
                        mul_dest <= bus.dest_in;
                        cnt      <= CNT_LOAD;
                        state    <= MUL_RUN;
                        busy_q   <= 1'b1;
                        ov_q     <= 1'b0;
                    end else if (accept) begin
                        res_q  <= alu_res;
                        st_q   <= s;
                        dest_q <= bus.dest_in;
                        ov_q   <= 1'b1;
                    end else if (!bus.mem_stall) begin
                        ov_q <= 1'b0;
                    end
                end
                MUL_RUN: begin
                    // The counter runs through stalls; only the write-back waits.
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                        if (!bus.mem_stall) begin
                            ov_q <= 1'b0;
                        end
                    end else if (!bus.mem_stall) begin
                        res_q  <= mul_lo;
                        st_q   <= mul_s;
                        dest_q <= mul_dest;
                        ov_q   <= 1'b1;
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        state <= MUL_HOLD;
                    end
                end
                MUL_HOLD: begin
                    if (!bus.mem_stall) begin
                        res_q  <= mul_lo;
                        st_q   <= mul_s;
                        dest_q <= mul_dest;
                        ov_q   <= 1'b1;
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.exe_busy     = busy_q;
    assign bus.out_valid    = ov_q;
    assign bus.ALUResult    = res_q;
    assign bus.ST_value_out = st_q;
    assign bus.dest_out     = dest_q;

endmodule

// File: tb/tb_exe_stage_mc.sv
// Bench for exe_stage_mc: vector table, directed multi-cycle sequences and
// a random run scored against an operation-level reference model.
module tb_exe_stage_mc;

    localparam int DW  = 32;
    localparam int TW  = 5;
    localparam int LAT = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    exe_stage_mc_if #(.DATA_W(DW), .DEST_W(TW)) bus ();

    exe_stage_mc #(.DATA_W(DW), .DEST_W(TW), .MUL_LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]    cmd;
        logic [1:0]    s1, s2, ss;
        logic [DW-1:0] v1, v2, st, mem, wb;
        logic [TW-1:0] dest;
        logic [DW-1:0] res, sto;
    } vec_t;

    typedef struct {
        logic [DW-1:0] r;
        logic [DW-1:0] s;
        logic [TW-1:0] d;
    } res_t;

    vec_t vt[24];
    int   nv = 0;
    res_t sb[$];
    logic last_acc = 1'b0;

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid    = 1'b0;
        bus.EXE_CMD     = 4'h0;
        bus.val1_sel    = 2'b00;
        bus.val2_sel    = 2'b00;
        bus.ST_val_sel  = 2'b00;
        bus.val1        = '0;
        bus.val2        = '0;
        bus.ST_value_in = '0;
        bus.ALU_res_MEM = '0;
        bus.result_WB   = '0;
        bus.dest_in     = '0;
        bus.mem_stall   = 1'b0;
    endtask

    task automatic present(input logic [3:0] cmd, input logic [1:0] s1, s2, ss,
                           input logic [DW-1:0] v1, v2, st, mem, wb,
                           input logic [TW-1:0] dest);
        bus.in_valid    = 1'b1;
        bus.EXE_CMD     = cmd;
        bus.val1_sel    = s1;
        bus.val2_sel    = s2;
        bus.ST_val_sel  = ss;
        bus.val1        = v1;
        bus.val2        = v2;
        bus.ST_value_in = st;
        bus.ALU_res_MEM = mem;
        bus.result_WB   = wb;
        bus.dest_in     = dest;
    endtask

    task automatic add_vec(input logic [3:0] cmd, input logic [1:0] s1, s2, ss,
                           input logic [DW-1:0] v1, v2, st, mem, wb,
                           input logic [TW-1:0] dest,
                           input logic [DW-1:0] res, sto);
        vt[nv].cmd = cmd;  vt[nv].s1 = s1;  vt[nv].s2 = s2;  vt[nv].ss = ss;
        vt[nv].v1 = v1;    vt[nv].v2 = v2;  vt[nv].st = st;
        vt[nv].mem = mem;  vt[nv].wb = wb;  vt[nv].dest = dest;
        vt[nv].res = res;  vt[nv].sto = sto;
        nv++;
    endtask

    function automatic logic [DW-1:0] fsel(input logic [1:0] sel,
                                           input logic [DW-1:0] own, mem, wb);
        if (sel == 2'b01) return mem;
        if (sel == 2'b10) return wb;
        return own;
    endfunction

    // Opcode semantics from plain arithmetic (sign handled by bias/complement).
    function automatic logic [DW-1:0] ref_alu(input logic [3:0] cmd, input logic [DW-1:0] a, b);
        int unsigned sh;
        logic [63:0] p;
        sh = int'(b[4:0]);
        case (cmd)
            4'd0:  return 32'd0;
            4'd1:  return a + b;
            4'd2:  return a - b;
            4'd3:  return a & b;
            4'd4:  return a | b;
            4'd5:  return a ^ b;
            4'd6:  return a << sh;
            4'd7:  return a >> sh;
            4'd8:  return a[31] ? ~((~a) >> sh) : (a >> sh);
            4'd9:  return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            4'd10: return (a < b) ? 32'd1 : 32'd0;
            4'd11: begin
                p = {32'd0, a} * {32'd0, b};
                return p[31:0];
            end
            default: return b;
        endcase
    endfunction

    function automatic logic [71:0] snap();
        return {2'b00, bus.out_valid, bus.ALUResult, bus.ST_value_out, bus.dest_out};
    endfunction

    task automatic run_cycle();
        logic        acc, stl;
        logic [71:0] pre;
        res_t        e;
        acc = bus.in_valid && !bus.exe_busy && !bus.mem_stall;
        stl = bus.mem_stall;
        pre = snap();
        if (acc) begin
            e.r = ref_alu(bus.EXE_CMD,
                          fsel(bus.val1_sel, bus.val1, bus.ALU_res_MEM, bus.result_WB),
                          fsel(bus.val2_sel, bus.val2, bus.ALU_res_MEM, bus.result_WB));
            e.s = fsel(bus.ST_val_sel, bus.ST_value_in, bus.ALU_res_MEM, bus.result_WB);
            e.d = bus.dest_in;
            sb.push_back(e);
        end
        tick();
        if (stl) begin
            chk("rnd_stall_freeze", snap(), pre);
        end else if (bus.out_valid) begin
            chk("rnd_result_expected", 72'(sb.size() > 0), 72'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("rnd_res",  72'(bus.ALUResult),    72'(e.r));
                chk("rnd_st",   72'(bus.ST_value_out), 72'(e.s));
                chk("rnd_dest", 72'(bus.dest_out),     72'(e.d));
            end
        end
        last_acc = acc;
    endtask

    initial begin
        logic [71:0] pre;
        idle_inputs();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_out_valid", 72'(bus.out_valid), 72'd0);
        chk("rst_busy",      72'(bus.exe_busy),  72'd0);
        chk("rst_res",       72'(bus.ALUResult), 72'd0);
        chk("rst_st",        72'(bus.ST_value_out), 72'd0);
        chk("rst_dest",      72'(bus.dest_out),  72'd0);

        // Forwarding selections, then the ALU sweep.
        add_vec(4'h1, 2'b01, 2'b10, 2'b10, 32'd5, 32'd3, 32'h55, 32'd7, 32'd9, 5'd1, 32'd16, 32'd9);
        add_vec(4'h1, 2'b11, 2'b00, 2'b00, 32'd5, 32'd3, 32'h55, 32'd7, 32'd9, 5'd2, 32'd8,  32'h55);
        add_vec(4'h1, 2'b10, 2'b01, 2'b01, 32'd5, 32'd3, 32'h55, 32'd7, 32'd9, 5'd3, 32'd16, 32'd7);
        add_vec(4'h1, 2'b00, 2'b11, 2'b11, 32'd5, 32'd3, 32'h55, 32'd7, 32'd9, 5'd4, 32'd8,  32'h55);
        add_vec(4'h0, 2'b00, 2'b00, 2'b00, 32'hFFFF_FFF0, 32'd4, 32'h1234_5678, 32'd0, 32'd0, 5'd5,  32'h0000_0000, 32'h1234_5678);
        add_vec(4'h1, 2'b00, 2'b00, 2'b00, 32'hFFFF_FFF0, 32'd4, 32'h1234_5678, 32'd0, 32'd0, 5'd6,  32'hFFFF_FFF4, 32'h1234_5678);
        add_vec(4'h2, 2'b00, 2'b00, 2'b00, 32'hFFFF_FFF0, 32'd4, 32'h1234_5678, 32'd0, 32'd0, 5'd7,  32'hFFFF_FFEC, 32'h1234_5678);
        add_vec(4'h3, 2'b00, 2'b00, 2'b00, 32'hFFFF_FFF0, 32'd4, 32'h1234_5678, 32'd0, 32'd0, 5'd8,  32'h0000_0000, 32'h1234_5678);
        add_vec(4'h4, 2'b00, 2'b00, 2'b00, 32'hFFFF_FFF0, 32'd4, 32'h1234_5678, 32'd0, 32'd0, 5'd9,  32'hFFFF_FFF4, 32'h1234_5678);
        add_vec(4'h5, 2'b00, 2'b00, 2'b00, 32'hFFFF_FFF0, 32'd4, 32'h1234_5678, 32'd0, 32'd0, 5'd10, 32'hFFFF_FFF4, 32'h1234_5678);
        add_vec(4'h6, 2'b00, 2'b00, 2'b00, 32'hFFFF_FFF0, 32'd4, 32'h1234_5678, 32'd0, 32'd0, 5'd11, 32'hFFFF_FF00, 32'h1234_5678);
        add_vec(4'h7, 2'b00, 2'b00, 2'b00, 32'hFFFF_FFF0, 32'd4, 32'h1234_5678, 32'd0, 32'd0, 5'd12, 32'h0FFF_FFFF, 32'h1234_5678);
        add_vec(4'h8, 2'b00, 2'b00, 2'b00, 32'hFFFF_FFF0, 32'd4, 32'h1234_5678, 32'd0, 32'd0, 5'd13, 32'hFFFF_FFFF, 32'h1234_5678);
        add_vec(4'h9, 2'b00, 2'b00, 2'b00, 32'hFFFF_FFF0, 32'd4, 32'h1234_5678, 32'd0, 32'd0, 5'd14, 32'd1, 32'h1234_5678);
        add_vec(4'hA, 2'b00, 2'b00, 2'b00, 32'hFFFF_FFF0, 32'd4, 32'h1234_5678, 32'd0, 32'd0, 5'd15, 32'd0, 32'h1234_5678);
        add_vec(4'hC, 2'b00, 2'b00, 2'b00, 32'hFFFF_FFF0, 32'd4, 32'h1234_5678, 32'd0, 32'd0, 5'd16, 32'd4, 32'h1234_5678);
        add_vec(4'hE, 2'b00, 2'b00, 2'b00, 32'hFFFF_FFF0, 32'd4, 32'h1234_5678, 32'd0, 32'd0, 5'd17, 32'd4, 32'h1234_5678);
        add_vec(4'hF, 2'b00, 2'b00, 2'b00, 32'hFFFF_FFF0, 32'd4, 32'h1234_5678, 32'd0, 32'd0, 5'd18, 32'd4, 32'h1234_5678);
        add_vec(4'h9, 2'b00, 2'b00, 2'b00, 32'd3, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 5'd19, 32'd0, 32'd0);
        add_vec(4'hA, 2'b00, 2'b00, 2'b00, 32'd3, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 5'd20, 32'd1, 32'd0);
        add_vec(4'h6, 2'b00, 2'b00, 2'b00, 32'd1, 32'h21, 32'd0, 32'd0, 32'd0, 5'd21, 32'd2, 32'd0);

        for (int i = 0; i < nv; i++) begin
            present(vt[i].cmd, vt[i].s1, vt[i].s2, vt[i].ss, vt[i].v1, vt[i].v2,
                    vt[i].st, vt[i].mem, vt[i].wb, vt[i].dest);
            tick();
            chk($sformatf("vec%0d_valid", i), 72'(bus.out_valid),    72'd1);
            chk($sformatf("vec%0d_res", i),   72'(bus.ALUResult),    72'(vt[i].res));
            chk($sformatf("vec%0d_st", i),    72'(bus.ST_value_out), 72'(vt[i].sto));
            chk($sformatf("vec%0d_dest", i),  72'(bus.dest_out),     72'(vt[i].dest));
        end
        idle_inputs();
        tick();
        chk("bubble_after_vec", 72'(bus.out_valid), 72'd0);

        // MUL wrap-around.
        present(4'hB, 2'b00, 2'b00, 2'b00, 32'h1_0000, 32'h1_0000, 32'd0, 32'd0, 32'd0, 5'd1);
        tick();
        idle_inputs();
        repeat (LAT) tick();
        chk("mul_wrap_valid", 72'(bus.out_valid), 72'd1);
        chk("mul_wrap_res",   72'(bus.ALUResult), 72'd0);

        // 3x7: busy exactly LAT cycles, forwarding inputs scrambled meanwhile.
        present(4'hB, 2'b00, 2'b00, 2'b00, 32'd3, 32'd7, 32'hBEEF, 32'd0, 32'd0, 5'd9);
        for (int e = 0; e <= LAT; e++) begin
            tick();
            bus.in_valid    = 1'b0;
            bus.val1        = $urandom;
            bus.val2        = $urandom;
            bus.ALU_res_MEM = $urandom;
            bus.result_WB   = $urandom;
            bus.ST_value_in = $urandom;
            bus.val1_sel    = 2'($urandom_range(0, 3));
            bus.val2_sel    = 2'($urandom_range(0, 3));
            chk($sformatf("mul_busy_e%0d", e),  72'(bus.exe_busy),  72'(e < LAT));
            chk($sformatf("mul_valid_e%0d", e), 72'(bus.out_valid), 72'(e == LAT));
        end
        chk("mul_res",  72'(bus.ALUResult),    72'd21);
        chk("mul_st",   72'(bus.ST_value_out), 72'hBEEF);
        chk("mul_dest", 72'(bus.dest_out),     72'd9);
        idle_inputs();
        tick();
        chk("mul_once", 72'(bus.out_valid), 72'd0);

        // mem_stall over edges 2..7 after accept.
        present(4'hB, 2'b00, 2'b00, 2'b00, 32'd6, 32'd7, 32'h77, 32'd0, 32'd0, 5'd3);
        tick();
        idle_inputs();
        for (int e = 1; e <= 9; e++) begin
            bus.mem_stall = (e >= 2 && e <= 7);
            pre = snap();
            tick();
            chk($sformatf("stall_busy_e%0d", e),  72'(bus.exe_busy),  72'(e <= 7));
            chk($sformatf("stall_valid_e%0d", e), 72'(bus.out_valid), 72'(e == 8));
            if (e >= 2 && e <= 7) chk($sformatf("stall_freeze_e%0d", e), snap(), pre);
            if (e == 8) chk("stall_res", 72'(bus.ALUResult), 72'd42);
        end
        idle_inputs();

        // Reset during MUL_RUN aborts the multiply.
        present(4'hB, 2'b00, 2'b00, 2'b00, 32'd5, 32'd5, 32'd0, 32'd0, 32'd0, 5'd6);
        tick();
        idle_inputs();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmul_busy",  72'(bus.exe_busy),  72'd0);
        chk("rstmul_valid", 72'(bus.out_valid), 72'd0);
        for (int e = 0; e < 8; e++) begin
            tick();
            chk($sformatf("rstmul_noprod_e%0d", e), 72'(bus.out_valid), 72'd0);
        end
        present(4'h1, 2'b00, 2'b00, 2'b00, 32'd1, 32'd1, 32'd0, 32'd0, 32'd0, 5'd4);
        tick();
        idle_inputs();
        chk("rstmul_add_valid", 72'(bus.out_valid), 72'd1);
        chk("rstmul_add_res",   72'(bus.ALUResult), 72'd2);
        tick();

        // ADD, MUL, ADD back-to-back with in_valid held.
        for (int e = 0; e < 7; e++) begin
            if (e == 0)      present(4'h1, 2'b00, 2'b00, 2'b00, 32'd10, 32'd20, 32'd0, 32'd0, 32'd0, 5'd1);
            else if (e == 1) present(4'hB, 2'b00, 2'b00, 2'b00, 32'd9, 32'd9, 32'd0, 32'd0, 32'd0, 5'd2);
            else             present(4'h1, 2'b00, 2'b00, 2'b00, 32'd100, 32'd1, 32'd0, 32'd0, 32'd0, 5'd3);
            tick();
            chk($sformatf("b2b_valid_e%0d", e), 72'(bus.out_valid), 72'(e == 0 || e >= 5));
            chk($sformatf("b2b_busy_e%0d", e),  72'(bus.exe_busy),  72'(e >= 1 && e <= 4));
            if (e == 0) chk("b2b_add1", 72'(bus.ALUResult), 72'd30);
            if (e == 5) chk("b2b_mul",  72'(bus.ALUResult), 72'd81);
            if (e == 6) chk("b2b_add2", 72'(bus.ALUResult), 72'd101);
        end
        idle_inputs();
        tick();
        chk("b2b_tail", 72'(bus.out_valid), 72'd0);

        // Random traffic against the scoreboard.
        last_acc = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (!bus.in_valid || last_acc) begin
                bus.in_valid    = ($urandom_range(0, 3) != 0);
                bus.EXE_CMD     = ($urandom_range(0, 4) == 0) ? 4'hB : 4'($urandom_range(0, 15));
                bus.val1_sel    = 2'($urandom_range(0, 3));
                bus.val2_sel    = 2'($urandom_range(0, 3));
                bus.ST_val_sel  = 2'($urandom_range(0, 3));
                bus.val1        = $urandom;
                bus.val2        = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
                bus.ST_value_in = $urandom;
                bus.dest_in     = 5'($urandom_range(0, 31));
            end
            bus.ALU_res_MEM = $urandom;
            bus.result_WB   = $urandom;
            bus.mem_stall   = ($urandom_range(0, 4) == 0);
            run_cycle();
        end
        idle_inputs();
        for (int c = 0; c < 30; c++) run_cycle();
        chk("rnd_scoreboard_empty", 72'(sb.size()), 72'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
